// File: rtl/io_pmp_cfg_ctrl_if.sv
// Register-port and commit-port bundle between the IO-PMP config master and io_pmp_cfg_ctrl.
// Every request is accepted on a cycle where valid && ready; responses and commit_done are unbackpressured pulses.
interface io_pmp_cfg_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             cfg_req_valid;
    logic             cfg_req_ready;
    logic             cfg_req_we;
    logic             cfg_req_sel;
    logic [IDX_W-1:0] cfg_req_idx;
    logic [63:0]      cfg_req_wdata;
    logic             cfg_resp_valid;
    logic [63:0]      cfg_resp_rdata;
    logic             cfg_resp_err;
    logic             commit_valid;
    logic             commit_ready;
    logic             commit_done;
    logic             commit_err;
    logic [1:0]       dbg_state;

    modport master (
        output cfg_req_valid, cfg_req_we, cfg_req_sel, cfg_req_idx, cfg_req_wdata, commit_valid,
        input  cfg_req_ready, cfg_resp_valid, cfg_resp_rdata, cfg_resp_err,
               commit_ready, commit_done, commit_err, dbg_state
    );

    modport slave (
        input  cfg_req_valid, cfg_req_we, cfg_req_sel, cfg_req_idx, cfg_req_wdata, commit_valid,
        output cfg_req_ready, cfg_resp_valid, cfg_resp_rdata, cfg_resp_err,
               commit_ready, commit_done, commit_err, dbg_state
    );
endinterface

// File: rtl/io_pmp_cfg_ctrl.sv
// IO-PMP configuration controller: shadow PMP registers behind a register port, committed to the
// active set only after the outstanding AXI transactions have drained.
module io_pmp_cfg_ctrl #(
    parameter int NUM_ENTRIES   = 16,
    parameter int PMP_LEN       = 54,
    parameter int OUTST_W       = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    io_pmp_cfg_ctrl_if.slave               bus,
    input  logic                           aw_hs,
    input  logic                           ar_hs,
    input  logic                           b_hs,
    input  logic                           rlast_hs,
    output logic                           stall_o,
    output logic [8*NUM_ENTRIES-1:0]       pmp_cfg_o,
    output logic [PMP_LEN*NUM_ENTRIES-1:0] pmp_addr_o
);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [OUTST_W-1:0] CNT_MAX  = '1;
    localparam logic [OUTST_W-1:0] CNT_HI   = CNT_MAX - 1'b1;

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, COMMIT = 2'd2} state_t;
    state_t state, state_nxt;

    logic [NUM_ENTRIES-1:0][7:0]         sh_cfg, act_cfg;
    logic [NUM_ENTRIES-1:0][PMP_LEN-1:0] sh_addr, act_addr;
    logic [NUM_ENTRIES-1:0]              cfg_lock, addr_lock;
    logic [OUTST_W-1:0]                  outst, outst_nxt;
    logic [TMO_W-1:0]                    tmo;
    logic [1:0]                          inc, dec;
    logic [OUTST_W+1:0]                  up, diff;
    logic                                fsm_stall, req_acc, commit_acc;
    logic                                unused_wdata;

    assign unused_wdata = ^{bus.cfg_req_wdata[63:PMP_LEN], bus.cfg_req_wdata[6:5]};

    // A TOR entry with L set also freezes the pmpaddr below it, since that address is its base.
    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_lock
        assign cfg_lock[i] = act_cfg[i][7];
        if (i < NUM_ENTRIES - 1) begin : g_tor
            assign addr_lock[i] = act_cfg[i][7] | (act_cfg[i+1][7] & (act_cfg[i+1][4:3] == 2'b01));
        end else begin : g_last
            assign addr_lock[i] = act_cfg[i][7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.cfg_req_ready = 1'b0;
        bus.commit_ready  = 1'b0;
        bus.commit_done   = 1'b0;
        bus.commit_err    = 1'b0;
        fsm_stall         = 1'b0;
        case (state)
            IDLE: begin
                bus.cfg_req_ready = ~bus.commit_valid;
                bus.commit_ready  = 1'b1;
                if (bus.commit_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                fsm_stall = 1'b1;
                if (outst == '0 && !aw_hs && !ar_hs) begin
                    state_nxt = COMMIT;
                end else if (tmo == TMO_LAST) begin
                    bus.commit_done = 1'b1;
                    bus.commit_err  = 1'b1;
                    state_nxt       = IDLE;
                end
            end
            COMMIT: begin
                fsm_stall       = 1'b1;
                bus.commit_done = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            bus.commit_done = 1'b0;
            bus.commit_err  = 1'b0;
        end
    end

    assign req_acc       = bus.cfg_req_valid & bus.cfg_req_ready;
    assign commit_acc    = bus.commit_valid & bus.commit_ready;
    assign stall_o       = fsm_stall | (outst >= CNT_HI);
    assign bus.dbg_state = state;
    assign pmp_cfg_o     = act_cfg;
    assign pmp_addr_o    = act_addr;

    // Saturating outstanding count, computed two bits wider so the net step cannot wrap.
    always_comb begin
        inc       = {1'b0, aw_hs} + {1'b0, ar_hs};
        dec       = {1'b0, b_hs} + {1'b0, rlast_hs};
        up        = {2'b00, outst} + {OUTST_W'(0), inc};
        diff      = up - {OUTST_W'(0), dec};
        outst_nxt = diff[OUTST_W-1:0];
        if (up < {OUTST_W'(0), dec})        outst_nxt = '0;
        else if (diff > {2'b00, CNT_MAX})   outst_nxt = CNT_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_cfg             <= '0;
            sh_addr            <= '0;
            act_cfg            <= '0;
            act_addr           <= '0;
            outst              <= '0;
            tmo                <= '0;
            bus.cfg_resp_valid <= 1'b0;
            bus.cfg_resp_rdata <= '0;
            bus.cfg_resp_err   <= 1'b0;
        end else begin
            bus.cfg_resp_valid <= req_acc;
            bus.cfg_resp_rdata <= '0;
            bus.cfg_resp_err   <= 1'b0;
            if (req_acc) begin
                if (!bus.cfg_req_we) begin
                    bus.cfg_resp_rdata <= bus.cfg_req_sel ? 64'(sh_addr[bus.cfg_req_idx])
                                                          : 64'(sh_cfg[bus.cfg_req_idx]);
                end else if (bus.cfg_req_sel) begin
                    if (addr_lock[bus.cfg_req_idx]) bus.cfg_resp_err <= 1'b1;
                    else sh_addr[bus.cfg_req_idx] <= bus.cfg_req_wdata[PMP_LEN-1:0];
                end else begin
                    if (cfg_lock[bus.cfg_req_idx]) bus.cfg_resp_err <= 1'b1;
                    else sh_cfg[bus.cfg_req_idx] <= {bus.cfg_req_wdata[7], 2'b00, bus.cfg_req_wdata[4:0]};
                end
            end
            if (state == COMMIT) begin
                act_cfg  <= sh_cfg;
                act_addr <= sh_addr;
            end
            outst <= outst_nxt;
            if (commit_acc)          tmo <= '0;
            else if (state == DRAIN) tmo <= tmo + 1'b1;
        end
    end
endmodule

// File: tb/tb_io_pmp_cfg_ctrl.sv
// Directed bench for io_pmp_cfg_ctrl: register-access vector table plus hand-written drain,
// saturation, timeout and reset sequences. Inputs change on negedge; outputs are sampled there too.
module tb_io_pmp_cfg_ctrl;
    localparam int N    = 16;
    localparam int PL   = 54;
    localparam int OW   = 8;
    localparam int TMO  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic aw_hs = 1'b0, ar_hs = 1'b0, b_hs = 1'b0, rlast_hs = 1'b0;
    logic stall_o;
    logic [8*N-1:0]  pmp_cfg_o;
    logic [PL*N-1:0] pmp_addr_o;

    io_pmp_cfg_ctrl_if #(.IDX_W(4)) bus();

    io_pmp_cfg_ctrl #(.NUM_ENTRIES(N), .PMP_LEN(PL), .OUTST_W(OW), .DRAIN_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .aw_hs(aw_hs), .ar_hs(ar_hs), .b_hs(b_hs), .rlast_hs(rlast_hs),
        .stall_o(stall_o), .pmp_cfg_o(pmp_cfg_o), .pmp_addr_o(pmp_addr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic        sel;
        logic [3:0]  idx;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t tbl[21];

    function automatic vec_t mk(input logic we, input logic sel, input logic [3:0] idx,
                                input logic [63:0] wd, input logic [63:0] rd, input logic err);
        vec_t v;
        v.we = we; v.sel = sel; v.idx = idx; v.wdata = wd; v.exp_rdata = rd; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_access(input logic we, input logic sel, input logic [3:0] idx,
                              input logic [63:0] wd, output logic rv, output logic [63:0] rd,
                              output logic err);
        @(negedge clk);
        bus.cfg_req_valid = 1'b1; bus.cfg_req_we = we; bus.cfg_req_sel = sel;
        bus.cfg_req_idx = idx; bus.cfg_req_wdata = wd;
        #1 chk("req_ready", bus.cfg_req_ready, 1'b1);
        @(negedge clk);
        bus.cfg_req_valid = 1'b0;
        #1;
        rv = bus.cfg_resp_valid; rd = bus.cfg_resp_rdata; err = bus.cfg_resp_err;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic rv, err;
        logic [63:0] rd;
        for (int i = lo; i < hi; i++) begin
            cfg_access(tbl[i].we, tbl[i].sel, tbl[i].idx, tbl[i].wdata, rv, rd, err);
            chk($sformatf("vec%0d_resp_valid", i), rv, 1'b1);
            chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
            if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
        end
    endtask

    task automatic pulse_hs(input logic aw, input logic ar, input logic b, input logic rl);
        @(negedge clk);
        aw_hs = aw; ar_hs = ar; b_hs = b; rlast_hs = rl;
        @(negedge clk);
        aw_hs = 1'b0; ar_hs = 1'b0; b_hs = 1'b0; rlast_hs = 1'b0;
        #1;
    endtask

    // Commit with nothing in flight: DRAIN one cycle, COMMIT the next, IDLE after.
    task automatic commit_quick(input string tag);
        @(negedge clk);
        bus.commit_valid = 1'b1;
        #1 chk({tag, "_commit_ready"}, bus.commit_ready, 1'b1);
        @(negedge clk);
        bus.commit_valid = 1'b0;
        #1 chk({tag, "_drain_stall"}, stall_o, 1'b1);
        chk({tag, "_drain_no_done"}, bus.commit_done, 1'b0);
        @(negedge clk);
        #1 chk({tag, "_done"}, bus.commit_done, 1'b1);
        chk({tag, "_done_err"}, bus.commit_err, 1'b0);
        chk({tag, "_commit_stall"}, stall_o, 1'b1);
        @(negedge clk);
        #1 chk({tag, "_idle_stall"}, stall_o, 1'b0);
        chk({tag, "_idle_done"}, bus.commit_done, 1'b0);
    endtask

    initial begin
        int k;
        logic rv, err;
        logic [63:0] rd;

        bus.cfg_req_valid = 1'b0; bus.cfg_req_we = 1'b0; bus.cfg_req_sel = 1'b0;
        bus.cfg_req_idx = '0; bus.cfg_req_wdata = '0; bus.commit_valid = 1'b0;

        tbl[0]  = mk(0, 1, 3, 64'h0,      64'h0,    0);
        tbl[1]  = mk(1, 0, 0, 64'hFF,     64'h0,    0);
        tbl[2]  = mk(1, 1, 0, 64'h1000,   64'h0,    0);
        tbl[3]  = mk(0, 0, 0, 64'h0,      64'h9F,   0);
        tbl[4]  = mk(0, 1, 0, 64'h0,      64'h1000, 0);
        tbl[5]  = mk(1, 0, 2, 64'h88,     64'h0,    0);
        tbl[6]  = mk(1, 1, 2, 64'h2222,   64'h0,    0);
        tbl[7]  = mk(1, 1, 1, 64'h1111,   64'h0,    0);
        tbl[8]  = mk(1, 1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0);
        tbl[9]  = mk(0, 1, 5, 64'h0,      64'h003F_FFFF_FFFF_FFFF, 0);
        tbl[10] = mk(1, 0, 2, 64'h00,     64'h0,    1);
        tbl[11] = mk(1, 1, 2, 64'h0,      64'h0,    1);
        tbl[12] = mk(1, 1, 1, 64'h0,      64'h0,    1);
        tbl[13] = mk(1, 1, 3, 64'h3333,   64'h0,    0);
        tbl[14] = mk(0, 0, 2, 64'h0,      64'h88,   0);
        tbl[15] = mk(0, 1, 2, 64'h0,      64'h2222, 0);
        tbl[16] = mk(0, 1, 1, 64'h0,      64'h1111, 0);
        tbl[17] = mk(0, 1, 3, 64'h0,      64'h3333, 0);
        tbl[18] = mk(1, 0, 0, 64'h01,     64'h0,    1);
        tbl[19] = mk(1, 0, 1, 64'h03,     64'h0,    0);
        tbl[20] = mk(0, 0, 1, 64'h0,      64'h03,   0);

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_pmp_cfg_nonzero", |pmp_cfg_o, 1'b0);
        chk("rst_pmp_addr_nonzero", |pmp_addr_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req_ready", bus.cfg_req_ready, 1'b1);
        chk("rst_commit_ready", bus.commit_ready, 1'b1);
        chk("rst_resp_valid", bus.cfg_resp_valid, 1'b0);
        chk("rst_commit_done", bus.commit_done, 1'b0);

        // Shadow writes/readback; active untouched until commit
        run_vecs(0, 10);
        chk("pre_commit_cfg", |pmp_cfg_o, 1'b0);
        chk("pre_commit_addr", |pmp_addr_o, 1'b0);
        commit_quick("c1");
        chk("c1_cfg0", 64'(pmp_cfg_o[7:0]), 64'h9F);
        chk("c1_cfg2", 64'(pmp_cfg_o[23:16]), 64'h88);
        chk("c1_addr0", 64'(pmp_addr_o[PL-1:0]), 64'h1000);
        chk("c1_addr1", 64'(pmp_addr_o[2*PL-1:PL]), 64'h1111);
        chk("c1_addr2", 64'(pmp_addr_o[3*PL-1:2*PL]), 64'h2222);
        chk("c1_addr5", 64'(pmp_addr_o[6*PL-1:5*PL]), 64'h003F_FFFF_FFFF_FFFF);

        // Lock rules against the committed set
        run_vecs(10, 21);

        // Drain with traffic in flight
        pulse_hs(1, 0, 0, 0); pulse_hs(1, 0, 0, 0); pulse_hs(1, 0, 0, 0); pulse_hs(0, 1, 0, 0);
        @(negedge clk);
        bus.commit_valid = 1'b1;
        @(negedge clk);
        bus.commit_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 chk("t3_hold_state", bus.dbg_state, 2'd1);
            chk("t3_hold_stall", stall_o, 1'b1);
            chk("t3_hold_done", bus.commit_done, 1'b0);
        end
        pulse_hs(0, 0, 1, 0); pulse_hs(0, 0, 1, 0); pulse_hs(0, 0, 1, 0);
        chk("t3_partial_state", bus.dbg_state, 2'd1);
        pulse_hs(0, 0, 0, 1);
        chk("t3_zero_state", bus.dbg_state, 2'd1);
        @(negedge clk);
        #1 chk("t3_done", bus.commit_done, 1'b1);
        chk("t3_err", bus.commit_err, 1'b0);
        @(negedge clk);
        #1 chk("t3_cfg1", 64'(pmp_cfg_o[15:8]), 64'h03);
        chk("t3_addr3", 64'(pmp_addr_o[4*PL-1:3*PL]), 64'h3333);
        chk("t3_idle_stall", stall_o, 1'b0);

        // Outstanding counter thresholds and saturation
        repeat (126) pulse_hs(1, 1, 0, 0);
        chk("sat_252_stall", stall_o, 1'b0);
        pulse_hs(1, 1, 0, 0);
        chk("sat_254_stall", stall_o, 1'b1);
        repeat (3) pulse_hs(1, 1, 0, 0);
        pulse_hs(0, 0, 1, 0);
        chk("sat_254b_stall", stall_o, 1'b1);
        pulse_hs(0, 0, 1, 0);
        chk("sat_253_stall", stall_o, 1'b0);
        repeat (126) pulse_hs(0, 0, 1, 1);
        pulse_hs(0, 0, 1, 0);
        pulse_hs(0, 0, 1, 1);
        commit_quick("c_floor");

        // Drain timeout with one write never answered
        cfg_access(1'b1, 1'b1, 4'd4, 64'h4444, rv, rd, err);
        chk("t5_wr_err", err, 1'b0);
        pulse_hs(1, 0, 0, 0);
        @(negedge clk);
        bus.commit_valid = 1'b1;
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            bus.commit_valid = 1'b0;
            k++;
            #1;
            if (bus.commit_done) break;
        end
        chk("t5_timeout_cycles", 64'(k), 64'(TMO));
        chk("t5_err", bus.commit_err, 1'b1);
        @(negedge clk);
        #1 chk("t5_stall_after", stall_o, 1'b0);
        chk("t5_state_after", bus.dbg_state, 2'd0);
        chk("t5_addr4_unchanged", 64'(pmp_addr_o[5*PL-1:4*PL]), 64'h0);
        chk("t5_cfg0_unchanged", 64'(pmp_cfg_o[7:0]), 64'h9F);

        // Commit beats a simultaneous register access; reset mid-DRAIN
        @(negedge clk);
        bus.commit_valid = 1'b1;
        bus.cfg_req_valid = 1'b1; bus.cfg_req_we = 1'b0; bus.cfg_req_sel = 1'b0; bus.cfg_req_idx = 4'd0;
        #1 chk("t6_req_ready", bus.cfg_req_ready, 1'b0);
        chk("t6_commit_ready", bus.commit_ready, 1'b1);
        @(negedge clk);
        bus.commit_valid = 1'b0; bus.cfg_req_valid = 1'b0;
        #1 chk("t6_no_resp", bus.cfg_resp_valid, 1'b0);
        chk("t6_drain", bus.dbg_state, 2'd1);
        chk("t6_drain_req_ready", bus.cfg_req_ready, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1 chk("t6_rst_no_done", bus.commit_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t6_state", bus.dbg_state, 2'd0);
        chk("t6_cfg_zero", |pmp_cfg_o, 1'b0);
        chk("t6_addr_zero", |pmp_addr_o, 1'b0);
        chk("t6_stall", stall_o, 1'b0);
        chk("t6_done", bus.commit_done, 1'b0);
        chk("t6_ready", bus.cfg_req_ready, 1'b1);
        cfg_access(1'b0, 1'b1, 4'd3, 64'h0, rv, rd, err);
        chk("t6_shadow_cleared", rd, 64'h0);
        commit_quick("c_post_rst");
        chk("t6_post_commit_cfg", |pmp_cfg_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_pmp_cfg_ctrl.md
Name: io_pmp_cfg_ctrl

Overview:
Configuration controller for the AXI IO-PMP. It holds shadow copies of the PMP entry configuration and address registers, written over a simple valid/ready register port. On commit, it stalls new AW/AR acceptance at the IO-PMP and waits for all in-flight transactions to drain. It then atomically copies shadow to active, so no transaction is ever checked against a half-updated rule set.

Parameters:
NUM_ENTRIES, 16, number of PMP entries (power of two, 2..64)
PMP_LEN, 54, width of each pmpaddr register in bits
OUTST_W, 8, width of the outstanding-transaction counter
DRAIN_TIMEOUT, 1024, maximum cycles spent in DRAIN before the commit aborts

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_req_valid  in  1  register access request
cfg_req_ready  out  1  request accepted when valid&ready
cfg_req_we  in  1  1=write, 0=read
cfg_req_sel  in  1  0=pmpcfg byte, 1=pmpaddr
cfg_req_idx  in  $clog2(NUM_ENTRIES)  entry index
cfg_req_wdata  in  64  write data; cfg uses [7:0], addr uses [PMP_LEN-1:0]
cfg_resp_valid  out  1  one-cycle response pulse
cfg_resp_rdata  out  64  shadow readback, zero-extended
cfg_resp_err  out  1  write refused because the entry is locked
commit_valid  in  1  commit request
commit_ready  out  1  commit accepted when valid&ready
commit_done  out  1  one-cycle pulse when the commit finishes or aborts
commit_err  out  1  qualifies commit_done; 1 = aborted on timeout
aw_hs  in  1  AW handshake at the IO-PMP slave port
ar_hs  in  1  AR handshake at the IO-PMP slave port
b_hs  in  1  B handshake at the IO-PMP slave port
rlast_hs  in  1  R handshake with rlast=1
stall_o  out  1  IO-PMP must hold awready/arready low
pmp_cfg_o  out  8*NUM_ENTRIES  active cfg bytes {L[7],A[4:3],X[2],W[1],R[0]}
pmp_addr_o  out  PMP_LEN*NUM_ENTRIES  active pmpaddr registers

Behaviour:
- Reset: all shadow and active registers = 0 (A=OFF, no access). State = IDLE. Counters = 0. All outputs 0 except cfg_req_ready = 1 and commit_ready = 1.
- FSM states are IDLE, DRAIN and COMMIT.
- IDLE:
  - cfg_req_ready = ~commit_valid, so a commit wins over a simultaneous register access.
  - commit_ready = 1.
  - Commit accept moves the FSM to DRAIN and clears the timeout counter.
- Register access:
  - Accepted only in IDLE.
  - Response pulse arrives exactly 1 cycle after accept; there is no backpressure on the response.
  - A read returns the shadow value.
  - A write updates the shadow unless the entry is locked. A locked write leaves the shadow unchanged and returns cfg_resp_err = 1.
  - For sel=0, bits [6:5] are written as 0 (WARL).
- Lock rule: entry i is locked if active cfg[i].L = 1. The pmpaddr of entry i-1 is also locked if active cfg[i].L = 1 and cfg[i].A = TOR (01). Lock is evaluated on active, not shadow, state.
- Outstanding counter:
  - Increments by (aw_hs + ar_hs) and decrements by (b_hs + rlast_hs); net update -2..+2 in one cycle.
  - Saturates at 0 and at 2^OUTST_W-1.
  - stall_o is also asserted whenever the counter >= 2^OUTST_W-2, independent of state.
- DRAIN:
  - stall_o = 1 from the cycle after commit accept.
  - cfg_req_ready = 0 and commit_ready = 0.
  - Handshakes completing in the accept cycle are still counted.
  - Go to COMMIT when counter == 0 and no aw_hs/ar_hs this cycle.
  - If the timeout counter reaches DRAIN_TIMEOUT-1 first: pulse commit_done with commit_err = 1, leave active unchanged, and return to IDLE.
- COMMIT (1 cycle):
  - Active <= shadow for all entries.
  - commit_done = 1, commit_err = 0.
  - stall_o stays 1 this cycle; next state is IDLE, where stall_o drops.
  - New values are visible on pmp_*_o the cycle after COMMIT.
- Reset asserted mid-DRAIN or mid-COMMIT: immediate return to IDLE with all registers cleared; no commit_done.
- Active outputs are registered; they change only in COMMIT or on reset.

Test Plan:
1. After reset: pmp_cfg_o = 0, pmp_addr_o = 0, stall_o = 0, cfg_req_ready = 1. Read idx 3 sel 1 -> resp 1 cycle later, rdata = 0, err = 0.
2. Write cfg[0] = 0xFF, addr[0] = 0x1000 -> readback cfg 0x9F, addr 0x1000. Active stays 0 until commit. Commit with no traffic -> commit_done in the COMMIT cycle (2 cycles after accept); pmp_cfg_o[7:0] = 0x9F the next cycle.
3. aw_hs ×3, ar_hs ×1, then commit -> stall_o = 1 and the FSM holds DRAIN. After 3 b_hs and 1 rlast_hs -> COMMIT on the next cycle, commit_err = 0.
4. Committed entry 2 with cfg = 0x88 (L=1, TOR) -> writes to cfg[2], addr[2] and addr[1] return err = 1 with shadow unchanged; a write to addr[3] succeeds.
5. One aw_hs with no B, then commit -> commit_done with commit_err = 1 exactly DRAIN_TIMEOUT cycles after accept; active unchanged; stall_o = 0 the next cycle.
6. commit_valid and cfg_req_valid asserted in the same cycle -> commit accepted, cfg_req_ready = 0. Reset 5 cycles into DRAIN -> IDLE, outputs 0, no commit_done.
